// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared 16-bit address / 8-bit data memory bus between the CPU6 core
// and a single DMA requester: hold, turnaround, bounded burst, then a guaranteed CPU window.
module mem_bus_arbiter #(
  parameter int HOLD_SETUP = 1,
  parameter int MAX_BURST  = 16,
  parameter int CPU_SLOTS  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data_out,
  input  logic        i_cpu_write_en,
  output logic [7:0]  o_cpu_data_in,
  output logic        o_cpu_hold,
  input  logic        i_dma_req,
  input  logic [15:0] i_dma_address,
  input  logic [7:0]  i_dma_data_out,
  input  logic        i_dma_write_en,
  input  logic        i_dma_last,
  output logic        o_dma_grant,
  output logic        o_dma_ack,
  output logic [7:0]  o_dma_data_in,
  output logic [15:0] o_mem_address,
  output logic [7:0]  o_mem_data_out,
  output logic        o_mem_write_en,
  input  logic [7:0]  i_mem_data_in
);

  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_SETUP);
  localparam logic [3:0] SLOT_LOAD   = 4'(CPU_SLOTS);
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_HOLD,
    ST_DMA,
    ST_RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_cpuHold;
  logic        r_dmaGrant;
  logic        r_dmaAck;
  logic [7:0]  r_dmaDataIn;
  logic [3:0]  r_holdCnt;
  logic [7:0]  r_burstCnt;
  logic [3:0]  r_slotCnt;

  logic        w_cpuHoldNext;
  logic        w_dmaGrantNext;
  logic        w_dmaAckNext;
  logic [7:0]  w_dmaDataInNext;
  logic [3:0]  w_holdNext;
  logic [7:0]  w_burstNext;
  logic [3:0]  w_slotNext;
  logic [7:0]  w_burstInc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_CPU;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cpuHold   <= 1'b0;
      r_dmaGrant  <= 1'b0;
      r_dmaAck    <= 1'b0;
      r_dmaDataIn <= 8'd0;
      r_holdCnt   <= 4'd0;
      r_burstCnt  <= 8'd0;
      r_slotCnt   <= 4'd0;
    end else begin
      r_cpuHold   <= w_cpuHoldNext;
      r_dmaGrant  <= w_dmaGrantNext;
      r_dmaAck    <= w_dmaAckNext;
      r_dmaDataIn <= w_dmaDataInNext;
      r_holdCnt   <= w_holdNext;
      r_burstCnt  <= w_burstNext;
      r_slotCnt   <= w_slotNext;
    end
  end

  // The CPU window is counted down on each CPU-owned edge; a pending request is
  // accepted on the edge where the remaining window reaches zero.
  always_comb begin
    w_nextState     = r_state;
    w_cpuHoldNext   = r_cpuHold;
    w_dmaGrantNext  = r_dmaGrant;
    w_dmaAckNext    = 1'b0;
    w_dmaDataInNext = r_dmaDataIn;
    w_holdNext      = r_holdCnt;
    w_burstNext     = r_burstCnt;
    w_slotNext      = r_slotCnt;
    w_burstInc      = r_burstCnt + 8'd1;

    case (r_state)
      ST_CPU: begin
        w_cpuHoldNext  = 1'b0;
        w_dmaGrantNext = 1'b0;
        w_slotNext     = (r_slotCnt != 4'd0) ? (r_slotCnt - 4'd1) : 4'd0;
        if ((w_slotNext == 4'd0) && i_dma_req) begin
          w_nextState   = ST_HOLD;
          w_holdNext    = HOLD_LOAD;
          w_cpuHoldNext = 1'b1;
        end
      end
      ST_HOLD: begin
        w_cpuHoldNext = 1'b1;
        if (r_holdCnt <= 4'd1) begin
          w_nextState    = ST_DMA;
          w_dmaGrantNext = 1'b1;
          w_burstNext    = 8'd0;
          w_holdNext     = 4'd0;
        end else begin
          w_holdNext = r_holdCnt - 4'd1;
        end
      end
      ST_DMA: begin
        w_cpuHoldNext  = 1'b1;
        w_dmaGrantNext = 1'b1;
        if (i_dma_req) begin
          w_burstNext  = w_burstInc;
          w_dmaAckNext = 1'b1;
          if (!i_dma_write_en) begin
            w_dmaDataInNext = i_mem_data_in;
          end
          if (i_dma_last || (w_burstInc >= BURST_LIMIT)) begin
            w_nextState    = ST_RELEASE;
            w_dmaGrantNext = 1'b0;
          end
        end else begin
          w_nextState    = ST_RELEASE;
          w_dmaGrantNext = 1'b0;
        end
      end
      ST_RELEASE: begin
        w_nextState    = ST_CPU;
        w_cpuHoldNext  = 1'b0;
        w_dmaGrantNext = 1'b0;
        w_slotNext     = SLOT_LOAD;
      end
      default: begin
        w_nextState    = ST_CPU;
        w_cpuHoldNext  = 1'b0;
        w_dmaGrantNext = 1'b0;
      end
    endcase
  end

  // During the turnaround cycles the CPU address stays on the bus but nothing is written.
  always_comb begin
    o_mem_address  = i_cpu_address;
    o_mem_data_out = i_cpu_data_out;
    o_mem_write_en = 1'b0;
    case (r_state)
      ST_CPU:  o_mem_write_en = i_cpu_write_en;
      ST_DMA: begin
        o_mem_address  = i_dma_address;
        o_mem_data_out = i_dma_data_out;
        o_mem_write_en = i_dma_write_en & i_dma_req;
      end
      default: o_mem_write_en = 1'b0;
    endcase
  end

  assign o_cpu_data_in = i_mem_data_in;
  assign o_cpu_hold    = r_cpuHold;
  assign o_dma_grant   = r_dmaGrant;
  assign o_dma_ack     = r_dmaAck;
  assign o_dma_data_in = r_dmaDataIn;

endmodule
